// File: rtl/exp_series_engine.sv
// Taylor-series e^x engine for an unsigned fraction x in [0,1). It alternates
// multiply-by-x and divide-by-k steps and stops early once a term truncates to zero.
module exp_series_engine #(
    parameter int X_W    = 16,
    parameter int FRAC_W = 16,
    parameter int INT_W  = 5,
    parameter int TERMS  = 8,
    parameter int TAG_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wStart,
    input  logic [X_W-1:0]           v,
    input  logic [TAG_W-1:0]         u,
    input  logic                     wrAck,
    output logic                     busy,
    output logic                     wrReq,
    output logic [INT_W+FRAC_W-1:0]  wrData,
    output logic [TAG_W-1:0]         wrTag,
    output logic                     wDone
);

    localparam int SW = INT_W + FRAC_W;
    localparam int RW = FRAC_W + 1;
    localparam int KW = 4;
    localparam logic [SW-1:0] ONE = {{(INT_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, MULX, DIVACC, WRITE, DONE} StateT;

    StateT              state, nextState;
    logic [X_W-1:0]     x;
    logic [TAG_W-1:0]   tag;
    logic [SW-1:0]      term, sum, t;
    logic [KW-1:0]      k;

    logic [SW+X_W-1:0]  mulProd;
    logic [SW-1:0]      p;
    logic [SW+RW-1:0]   divProd;
    logic [SW-1:0]      q;
    logic [SW:0]        sumExt;
    logic [SW-1:0]      sumSat;
    logic [RW-1:0]      recip;
    logic               lastTerm;

    // Reciprocal ROM: floor(2^FRAC_W / k), folded to constants at elaboration.
    always_comb begin
        recip = '0;
        case (k)
            4'd1:  recip = RW'((64'd1 << FRAC_W) / 1);
            4'd2:  recip = RW'((64'd1 << FRAC_W) / 2);
            4'd3:  recip = RW'((64'd1 << FRAC_W) / 3);
            4'd4:  recip = RW'((64'd1 << FRAC_W) / 4);
            4'd5:  recip = RW'((64'd1 << FRAC_W) / 5);
            4'd6:  recip = RW'((64'd1 << FRAC_W) / 6);
            4'd7:  recip = RW'((64'd1 << FRAC_W) / 7);
            4'd8:  recip = RW'((64'd1 << FRAC_W) / 8);
            4'd9:  recip = RW'((64'd1 << FRAC_W) / 9);
            4'd10: recip = RW'((64'd1 << FRAC_W) / 10);
            4'd11: recip = RW'((64'd1 << FRAC_W) / 11);
            4'd12: recip = RW'((64'd1 << FRAC_W) / 12);
            4'd13: recip = RW'((64'd1 << FRAC_W) / 13);
            4'd14: recip = RW'((64'd1 << FRAC_W) / 14);
            4'd15: recip = RW'((64'd1 << FRAC_W) / 15);
            default: recip = '0;
        endcase
    end

    always_comb begin
        mulProd  = (SW+X_W)'(term) * (SW+X_W)'(x);
        p        = SW'(mulProd >> X_W);
        divProd  = (SW+RW)'(t) * (SW+RW)'(recip);
        q        = SW'(divProd >> FRAC_W);
        sumExt   = {1'b0, sum} + {1'b0, q};
        sumSat   = sumExt[SW] ? {SW{1'b1}} : sumExt[SW-1:0];
        lastTerm = (k == KW'(TERMS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (wStart) nextState = MULX;
            MULX:    nextState = (p == '0) ? WRITE : DIVACC;
            DIVACC:  nextState = lastTerm ? WRITE : MULX;
            WRITE:   if (wrAck) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Result is gated to zero outside WRITE so nothing partial is ever visible.
    always_comb begin
        busy   = (state != IDLE);
        wrReq  = (state == WRITE);
        wrData = (state == WRITE) ? sum : '0;
        wrTag  = (state == WRITE) ? tag : '0;
        wDone  = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            tag  <= '0;
            term <= '0;
            sum  <= '0;
            t    <= '0;
            k    <= '0;
        end else begin
            case (state)
                IDLE: if (wStart) begin
                    x    <= v;
                    tag  <= u;
                    term <= ONE;
                    sum  <= ONE;
                    k    <= KW'(1);
                end
                MULX: if (p != '0) t <= p;
                DIVACC: begin
                    term <= q;
                    sum  <= sumSat;
                    if (!lastTerm) k <= k + KW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_series_engine.sv
// Scoreboard bench for exp_series_engine: stimulus pushes expected writes,
// a negedge monitor pops and checks them as the engine presents results.
module tb_exp_series_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        wStart;
    logic [15:0] v;
    logic [1:0]  u;
    logic        wrAck;
    logic        busy, wrReq, wDone;
    logic [20:0] wrData;
    logic [1:0]  wrTag;

    typedef struct {
        logic [20:0] data;
        logic [1:0]  tag;
        int          hold;
    } ExpT;

    ExpT sb[$];
    int  checks = 0;
    int  errors = 0;

    exp_series_engine #(.X_W(16), .FRAC_W(16), .INT_W(5), .TERMS(8), .TAG_W(2)) dut (
        .clk(clk), .rst(rst), .wStart(wStart), .v(v), .u(u), .wrAck(wrAck),
        .busy(busy), .wrReq(wrReq), .wrData(wrData), .wrTag(wrTag), .wDone(wDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference series evaluation with the same truncation rules; also reports exit latency.
    function automatic logic [20:0] model(input logic [15:0] xv, output int lat);
        logic [20:0] term, sum, t;
        logic [36:0] mp;
        logic [37:0] dp;
        logic [21:0] s;
        term = 21'h10000;
        sum  = 21'h10000;
        lat  = 14;
        for (int k = 1; k < 8; k++) begin
            mp = 37'(term) * 37'(xv);
            if ((mp >> 16) == 0) begin
                lat = 2 * (k - 1) + 1;
                break;
            end
            t    = 21'(mp >> 16);
            dp   = 38'(t) * 38'(65536 / k);
            term = 21'(dp >> 16);
            s    = 22'(sum) + 22'(term);
            sum  = s[21] ? 21'h1FFFFF : s[20:0];
        end
        return sum;
    endfunction

    // Monitor: checks hold length, stability, data/tag on accept, and the wDone pulse.
    logic [20:0] prevData;
    logic [1:0]  prevTag;
    int          holdCnt = 0;
    logic        expectDone = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            holdCnt    = 0;
            expectDone = 1'b0;
        end else begin
            if (expectDone || wDone) begin
                checkOutput("wDone pulse", {62'd0, wDone, wrReq}, {62'd0, expectDone, 1'b0});
            end
            expectDone = 1'b0;
            if (wrReq) begin
                holdCnt++;
                if (holdCnt > 1) begin
                    checkOutput("held wrData", wrData, prevData);
                    checkOutput("held wrTag", wrTag, prevTag);
                end
                prevData = wrData;
                prevTag  = wrTag;
                if (wrAck) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected write", 64'd1, 64'd0);
                    end else begin
                        ExpT e;
                        e = sb.pop_front();
                        checkOutput("wrData", wrData, e.data);
                        checkOutput("wrTag", wrTag, e.tag);
                        checkOutput("wrReq hold cycles", holdCnt, e.hold);
                    end
                    holdCnt    = 0;
                    expectDone = 1'b1;
                end
            end
        end
    end

    task automatic waitDone();
        int n = 0;
        while (!wDone && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("wDone reached", {63'd0, wDone}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input logic [15:0] vv, input logic [1:0] uu, input int ackDelay,
                                 input int expLat, input logic [20:0] expData);
        int lat;
        sb.push_back('{expData, uu, ackDelay + 1});
        @(posedge clk); #1;
        wStart = 1'b1; v = vv; u = uu; wrAck = (ackDelay == 0);
        @(posedge clk); #1;
        wStart = 1'b0;
        lat = 0;
        while (!wrReq && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("start-to-wrReq edges", lat, expLat);
        if (ackDelay > 0) begin
            repeat (ackDelay) @(posedge clk);
            #1 wrAck = 1'b1;
        end
        waitDone();
    endtask

    initial begin
        int lat, n, gap, wrSeen;
        logic [20:0] mFF;
        rst = 1'b1; wStart = 1'b0; v = '0; u = '0; wrAck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset outputs", {wrData, wrTag, busy, wrReq, wDone}, 64'd0);
        rst = 1'b0;

        // Hand-traced vectors: data and edges from start to wrReq.
        applyStimulus(16'h1F00, 2'd2, 0, 9, 21'h120F3);
        applyStimulus(16'h0F00, 2'd1, 0, 7, 21'h10F71);
        applyStimulus(16'h0000, 2'd0, 0, 1, 21'h10000);
        applyStimulus(16'h0001, 2'd3, 0, 3, 21'h10001);

        mFF = model(16'hFFFF, lat);
        applyStimulus(16'hFFFF, 2'd1, 10, 14, mFF);
        checkOutput("e^1 approx range", {63'd0, (mFF > 21'd178000) && (mFF <= 21'd178145)}, 64'd1);

        // Starts offered during MULX and WRITE must be ignored.
        sb.push_back('{21'h10F71, 2'd1, 4});
        @(posedge clk); #1;
        wStart = 1'b1; v = 16'h0F00; u = 2'd1; wrAck = 1'b0;
        @(posedge clk); #1 wStart = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wStart = 1'b1; v = 16'hFFFF; u = 2'd3;
        @(posedge clk); #1 wStart = 1'b0;
        n = 0;
        while (!wrReq && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        wStart = 1'b1; v = 16'h0000; u = 2'd0;
        @(posedge clk); #1 wStart = 1'b0;
        repeat (2) @(posedge clk);
        #1 wrAck = 1'b1;
        waitDone();
        @(posedge clk); #1;
        checkOutput("idle after ignored starts", {63'd0, busy}, 64'd0);

        // wStart held high: back-to-back full evaluations.
        sb.push_back('{mFF, 2'd2, 1});
        sb.push_back('{mFF, 2'd2, 1});
        @(posedge clk); #1;
        wStart = 1'b1; v = 16'hFFFF; u = 2'd2; wrAck = 1'b1;
        n = 0;
        while (!wDone && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        gap = 0;
        @(posedge clk); #1;
        gap++;
        while (!wDone && gap < 100) begin
            @(posedge clk); #1;
            gap++;
        end
        wStart = 1'b0;
        checkOutput("back-to-back spacing", gap, 17);
        repeat (3) @(posedge clk);
        #1 checkOutput("idle after back-to-back", {63'd0, busy}, 64'd0);

        // Asynchronous reset in the middle of DIVACC kills the operation.
        @(posedge clk); #1;
        wStart = 1'b1; v = 16'hFFFF; u = 2'd3; wrAck = 1'b1;
        @(posedge clk); #1 wStart = 1'b0;
        @(posedge clk); #1;
        checkOutput("busy before reset", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1 checkOutput("async reset outputs", {wrData, wrTag, busy, wrReq, wDone}, 64'd0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        wrSeen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (wrReq || wDone || busy) wrSeen++;
        end
        checkOutput("no activity after reset", wrSeen, 0);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checkOutput("scoreboard drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
